// File: rtl/m_counter_pkg.sv
// Shared types and helpers for the multi-mode counter family.
package m_counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP_WRAP     = 2'd0,
    MODE_DOWN_RELOAD = 2'd1,
    MODE_ONESHOT     = 2'd2,
    MODE_UP_SAT      = 2'd3
  } mode_t;

  // Terminal condition for the current count in a given mode. Operands are
  // widened to 32 bits so one function serves every counter width.
  function automatic logic term_cond(input mode_t mode,
                                     input logic [31:0] q,
                                     input logic [31:0] max);
    case (mode)
      MODE_UP_WRAP:     term_cond = (q == max);
      MODE_DOWN_RELOAD: term_cond = (q == 32'd0);
      MODE_ONESHOT:     term_cond = (q == 32'd1);
      default:          term_cond = (q == (max - 32'd1));
    endcase
  endfunction

endpackage

// File: rtl/m_register.sv
// Generic loadable register with synchronous clear; clear beats enable.
module m_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next value: clear, load or hold.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = d;
    end
  end

  // Storage.
  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/m_mode_counter.sv
// Multi-mode counter: free wrap, auto-reload divider, one-shot, saturating up.
// co is combinational so stages can be chained (next en = this co); tc is
// co registered one clock later.
module m_mode_counter
  import m_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             co,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  mode_t            mode_w;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  logic             rld_en;
  logic             done_q, done_d;
  logic             tc_q, tc_d;
  logic             term;

  assign mode_w = mode_t'(mode);
  assign term   = term_cond(mode_w, 32'(q_q), 32'(MAX));
  assign co     = en & ~clr & ~load & clr_n & term;
  assign tc_d   = co;

  // Reload value: reset forces zero through the enable path, clr leaves it.
  assign rld_en = ~clr_n | (load & ~clr);
  assign rld_d  = clr_n ? D : '0;

  m_register #(.WIDTH(WIDTH)) u_rld (
    .clk (clk),
    .clr (1'b0),
    .en  (rld_en),
    .d   (rld_d),
    .q   (rld_q)
  );

  // Next count and done: clr > load > en; modes 0/1 never hold done.
  always_comb begin
    q_d    = q_q;
    done_d = done_q;
    if (clr) begin
      q_d    = '0;
      done_d = 1'b0;
    end else if (load) begin
      q_d    = D;
      done_d = (mode_w == MODE_ONESHOT) && (D == '0);
    end else begin
      if (en) begin
        case (mode_w)
          MODE_UP_WRAP: q_d = q_q + ONE;
          MODE_DOWN_RELOAD: begin
            if (q_q == '0) q_d = rld_q;
            else           q_d = q_q - ONE;
          end
          MODE_ONESHOT: begin
            if (q_q != '0) begin
              q_d = q_q - ONE;
              if (term) done_d = 1'b1;
            end
          end
          default: begin
            if (q_q != MAX) begin
              q_d = q_q + ONE;
              if (term) done_d = 1'b1;
            end
          end
        endcase
      end
      if ((mode_w == MODE_UP_WRAP) || (mode_w == MODE_DOWN_RELOAD)) begin
        done_d = 1'b0;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      q_q    <= '0;
      done_q <= 1'b0;
      tc_q   <= 1'b0;
    end else begin
      q_q    <= q_d;
      done_q <= done_d;
      tc_q   <= tc_d;
    end
  end

  assign Q    = q_q;
  assign tc   = tc_q;
  assign done = done_q;

endmodule

// File: tb/tb_m_mode_counter.sv
// Bench for m_mode_counter: 8-bit and 4-bit instances driven in lockstep
// against a behavioural model, plus a two-stage 8-bit cascade.
module tb_m_mode_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr_n, clr, load, en;
  logic [1:0] mode;
  logic [7:0] d8;
  logic [3:0] d4;
  logic [7:0] q8;
  logic       co8, tc8, done8;
  logic [3:0] q4;
  logic       co4, tc4, done4;

  logic       c_load, c_en;
  logic [7:0] c_d, qa, qb;
  logic       coa, cob, tca, tcb, donea, doneb;

  m_mode_counter #(.WIDTH(8)) u_dut8 (
    .clk(clk), .clr_n(clr_n), .clr(clr), .load(load), .en(en), .mode(mode),
    .D(d8), .Q(q8), .co(co8), .tc(tc8), .done(done8));

  m_mode_counter #(.WIDTH(4)) u_dut4 (
    .clk(clk), .clr_n(clr_n), .clr(clr), .load(load), .en(en), .mode(mode),
    .D(d4), .Q(q4), .co(co4), .tc(tc4), .done(done4));

  m_mode_counter #(.WIDTH(8)) u_casc_a (
    .clk(clk), .clr_n(clr_n), .clr(1'b0), .load(c_load), .en(c_en), .mode(2'd0),
    .D(c_d), .Q(qa), .co(coa), .tc(tca), .done(donea));

  m_mode_counter #(.WIDTH(8)) u_casc_b (
    .clk(clk), .clr_n(clr_n), .clr(1'b0), .load(c_load), .en(coa), .mode(2'd0),
    .D(c_d), .Q(qb), .co(cob), .tc(tcb), .done(doneb));

  int    n_tests = 0;
  int    n_fail  = 0;
  string phase   = "init";

  int mq[2];
  int mrld[2];
  int mmax[2];
  bit mdone[2];
  bit mtc[2];

  int dr_q[8]   = '{2, 1, 0, 3, 2, 1, 0, 3};
  int dr_tc[8]  = '{0, 0, 0, 1, 0, 0, 0, 1};
  int os_q[4]   = '{1, 0, 0, 0};
  int os_tc[4]  = '{0, 1, 0, 0};
  int os_dn[4]  = '{0, 1, 1, 1};
  int st_q[6]   = '{14, 15, 15, 15, 15, 15};
  int st_tc[6]  = '{0, 1, 0, 0, 0, 0};
  int st_dn[6]  = '{0, 1, 1, 1, 1, 1};
  int g_en[4]   = '{0, 1, 0, 1};
  int g_q[4]    = '{1, 0, 0, 1};
  int g_tc[4]   = '{0, 0, 0, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0d expected %0d", phase, tag, obs, exp);
    end
  endtask

  function automatic int dval(input int i);
    return (i == 0) ? int'(d8) : int'(d4);
  endfunction

  // Terminal event this cycle, straight from the mode rules.
  function automatic bit model_co(input int i);
    if (!clr_n || clr || load || !en) return 1'b0;
    case (mode)
      2'd0:    return mq[i] == mmax[i];
      2'd1:    return mq[i] == 0;
      2'd2:    return mq[i] == 1;
      default: return mq[i] == mmax[i] - 1;
    endcase
  endfunction

  function automatic void model_edge(input int i, input bit c);
    mtc[i] = c;
    if (!clr_n) begin
      mq[i] = 0; mrld[i] = 0; mdone[i] = 1'b0; mtc[i] = 1'b0;
    end else if (clr) begin
      mq[i] = 0; mdone[i] = 1'b0;
    end else if (load) begin
      mq[i] = dval(i); mrld[i] = dval(i);
      mdone[i] = (mode == 2'd2) && (dval(i) == 0);
    end else begin
      if (en) begin
        case (mode)
          2'd0: mq[i] = (mq[i] + 1) % (mmax[i] + 1);
          2'd1: mq[i] = (mq[i] == 0) ? mrld[i] : mq[i] - 1;
          2'd2: if (mq[i] != 0) begin
                  if (mq[i] == 1) mdone[i] = 1'b1;
                  mq[i] = mq[i] - 1;
                end
          default: if (mq[i] != mmax[i]) begin
                  if (mq[i] == mmax[i] - 1) mdone[i] = 1'b1;
                  mq[i] = mq[i] + 1;
                end
        endcase
      end
      if (mode < 2'd2) mdone[i] = 1'b0;
    end
  endfunction

  task automatic drv(input bit cn, input bit c, input bit l, input bit e,
                     input logic [1:0] m, input logic [7:0] dv);
    clr_n = cn; clr = c; load = l; en = e; mode = m; d8 = dv; d4 = dv[3:0];
  endtask

  // One clock: check co before the edge, advance the model, check registers.
  task automatic step();
    bit eco0, eco1;
    eco0 = model_co(0);
    eco1 = model_co(1);
    #1;
    chk("co8", 32'(co8), 32'(eco0));
    chk("co4", 32'(co4), 32'(eco1));
    @(posedge clk);
    #1;
    model_edge(0, eco0);
    model_edge(1, eco1);
    chk("q8",    32'(q8),    32'(mq[0]));
    chk("tc8",   32'(tc8),   32'(mtc[0]));
    chk("done8", 32'(done8), 32'(mdone[0]));
    chk("q4",    32'(q4),    32'(mq[1]));
    chk("tc4",   32'(tc4),   32'(mtc[1]));
    chk("done4", 32'(done4), 32'(mdone[1]));
  endtask

  initial begin
    logic [15:0] cnt;
    bit          pa, pb;
    int          hits;
    logic [1:0]  cur_mode;

    mmax[0] = 255; mmax[1] = 15;
    for (int i = 0; i < 2; i++) begin
      mq[i] = 0; mrld[i] = 0; mdone[i] = 1'b0; mtc[i] = 1'b0;
    end
    c_load = 1'b0; c_en = 1'b0; c_d = 8'hFE;
    drv(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);

    phase = "reset";
    step();
    step();

    phase = "down_reload";
    drv(1, 0, 1, 0, 2'd1, 8'd3);
    step();
    for (int k = 0; k < 8; k++) begin
      drv(1, 0, 0, 1, 2'd1, 8'd0);
      step();
      chk("dr_q",  32'(q8),  32'(dr_q[k]));
      chk("dr_tc", 32'(tc8), 32'(dr_tc[k]));
    end

    phase = "oneshot";
    drv(1, 0, 1, 0, 2'd2, 8'd2);
    step();
    for (int k = 0; k < 4; k++) begin
      drv(1, 0, 0, 1, 2'd2, 8'd0);
      step();
      chk("os_q",    32'(q8),    32'(os_q[k]));
      chk("os_tc",   32'(tc8),   32'(os_tc[k]));
      chk("os_done", 32'(done8), 32'(os_dn[k]));
    end
    drv(1, 0, 1, 0, 2'd2, 8'd0);
    step();
    chk("os_ld0_done", 32'(done8), 32'd1);
    chk("os_ld0_tc",   32'(tc8),   32'd0);
    drv(1, 1, 0, 0, 2'd2, 8'd0);
    step();
    chk("os_clr_done", 32'(done8), 32'd0);
    chk("os_clr_q",    32'(q8),    32'd0);

    phase = "up_sat";
    drv(1, 0, 1, 0, 2'd3, 8'd13);
    step();
    for (int k = 0; k < 6; k++) begin
      drv(1, 0, 0, 1, 2'd3, 8'd0);
      step();
      chk("sat_q",    32'(q4),    32'(st_q[k]));
      chk("sat_tc",   32'(tc4),   32'(st_tc[k]));
      chk("sat_done", 32'(done4), 32'(st_dn[k]));
    end

    phase = "priority";
    drv(1, 0, 1, 1, 2'd1, 8'd5);
    step();
    chk("load_over_en", 32'(q8), 32'd5);
    drv(1, 0, 0, 1, 2'd1, 8'd0);
    step();
    drv(0, 0, 1, 1, 2'd1, 8'd9);
    step();
    chk("rst_q",    32'(q8),    32'd0);
    chk("rst_tc",   32'(tc8),   32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    drv(1, 0, 0, 1, 2'd1, 8'd0);
    step();
    chk("rst_rld_q", 32'(q8), 32'd0);
    step();
    chk("rst_rld_tc", 32'(tc8), 32'd1);

    phase = "clrn_glitch";
    drv(1, 0, 1, 0, 2'd1, 8'd7);
    step();
    clr_n = 1'b0;
    #2;
    clr_n = 1'b1;
    drv(1, 0, 0, 0, 2'd1, 8'd0);
    step();
    chk("glitch_q", 32'(q8), 32'd7);

    phase = "en_gating";
    drv(1, 0, 1, 0, 2'd1, 8'd1);
    step();
    for (int k = 0; k < 4; k++) begin
      drv(1, 0, 0, 1'(g_en[k]), 2'd1, 8'd0);
      step();
      chk("gate_q",  32'(q8),  32'(g_q[k]));
      chk("gate_tc", 32'(tc8), 32'(g_tc[k]));
    end

    phase = "cascade";
    drv(1, 0, 0, 0, 2'd0, 8'd0);
    c_load = 1'b1;
    step();
    c_load = 1'b0;
    c_en   = 1'b1;
    cnt  = 16'hFEFE;
    pa   = 1'b0;
    pb   = 1'b0;
    hits = 0;
    chk("casc_ld_a", 32'(qa), 32'hFE);
    chk("casc_ld_b", 32'(qb), 32'hFE);
    for (int k = 0; k < 260; k++) begin
      step();
      cnt = cnt + 16'd1;
      chk("casc_a",  32'(qa),  32'(cnt[7:0]));
      chk("casc_b",  32'(qb),  32'(cnt[15:8]));
      chk("casc_tca", 32'(tca), 32'(pa));
      chk("casc_tcb", 32'(tcb), 32'(pb));
      pa = (cnt[7:0] == 8'hFF);
      pb = (cnt == 16'hFFFF);
      chk("casc_coa", 32'(coa), 32'(pa));
      chk("casc_cob", 32'(cob), 32'(pb));
      chk("casc_done", 32'({donea, doneb}), 32'd0);
      if (cob) hits++;
      if (k == 1) begin
        chk("casc_2tick_a", 32'(qa), 32'h00);
        chk("casc_2tick_b", 32'(qb), 32'hFF);
      end
    end
    chk("casc_cob_once", 32'(hits), 32'd1);
    c_en = 1'b0;

    phase = "random";
    cur_mode = 2'd0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 15) == 0) cur_mode = 2'($urandom_range(0, 3));
      drv(($urandom_range(0, 99) != 0),
          ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 3) != 0),
          cur_mode,
          8'($urandom));
      d4 = 4'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
